// File: rtl/full_adder.sv
// Single-bit full adder with a registered copy of its result. In bit-serial mode the
// registered carry is fed back as carry-in, so words are added LSB-first one bit per clock.
module full_adder (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic serial_en,
    output logic s,
    output logic Cout,
    output logic s_q,
    output logic cout_q,
    output logic valid_q
);

    logic c_eff;

    // The first bit of a serial word runs with serial_en=0, so a stale carry never leaks in.
    assign c_eff = serial_en ? cout_q : cin;

    assign s    = a ^ b ^ c_eff;
    assign Cout = (a & b) | (a & c_eff) | (b & c_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s;
            cout_q  <= Cout;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: combinational truth table, registered path,
// serial word addition, asynchronous reset and carry-source selection.
module tb_full_adder;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst, a, b, cin, serial_en;
    logic s, Cout, s_q, cout_q, valid_q;

    int checks = 0;
    int failures = 0;

    // Scoreboard: expected {cout_q, s_q} pushed when a bit is driven, popped after the edge.
    logic [1:0] exp_q[$];
    logic       model_c;

    full_adder dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .serial_en(serial_en),
        .s(s), .Cout(Cout), .s_q(s_q), .cout_q(cout_q), .valid_q(valid_q)
    );

    // Clock only toggles when enabled, so the first test sees no edges at all.
    always #5 if (clk_run) clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    // Drive one bit, check the combinational result against the model, push the registered expectation.
    task automatic drive_bit(input logic ai, input logic bi, input logic ci, input logic sen);
        logic       ce;
        logic [1:0] sum;
        a = ai; b = bi; cin = ci; serial_en = sen;
        ce  = sen ? model_c : ci;
        sum = {1'b0, ai} + {1'b0, bi} + {1'b0, ce};
        #1;
        checks++;
        if ({Cout, s} !== sum) begin
            failures++;
            $display("FAIL comb_bit a=%0b b=%0b cin=%0b sen=%0b: got {Cout,s}=%b expected %b",
                     ai, bi, ci, sen, {Cout, s}, sum);
        end
        exp_q.push_back(sum);
    endtask

    // Take one rising edge, then compare the registers against the scoreboard head.
    task automatic clock_edge();
        logic [1:0] exp;
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got s_q=%0b cout_q=%0b with no expectation", s_q, cout_q);
        end else begin
            exp = exp_q.pop_front();
            model_c = exp[1];
            if ({cout_q, s_q, valid_q} !== {exp, 1'b1}) begin
                failures++;
                $display("FAIL reg_bit: got cout_q=%0b s_q=%0b valid_q=%0b expected %0b %0b 1",
                         cout_q, s_q, valid_q, exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; a = 1'b1; b = 1'b0; cin = 1'b0; serial_en = 1'b0;
        #100;
        checks++;
        if ({s, Cout} !== 2'b10) begin
            failures++;
            $display("FAIL noclk_rst0: got s=%0b Cout=%0b expected s=1 Cout=0", s, Cout);
        end
        rst = 1'b1;
        #100;
        checks++;
        if ({s, Cout} !== 2'b10) begin
            failures++;
            $display("FAIL noclk_rst1: got s=%0b Cout=%0b expected s=1 Cout=0", s, Cout);
        end
        checks++;
        if ({s_q, cout_q, valid_q} !== 3'b000) begin
            failures++;
            $display("FAIL reset_regs: got s_q=%0b cout_q=%0b valid_q=%0b expected 0 0 0", s_q, cout_q, valid_q);
        end
        // While cout_q is held at 0, serial mode adds a+b+0.
        serial_en = 1'b1; a = 1'b1; b = 1'b1;
        #1;
        checks++;
        if ({Cout, s} !== 2'b10) begin
            failures++;
            $display("FAIL serial_in_reset: got {Cout,s}=%b expected 10", {Cout, s});
        end
        serial_en = 1'b0;
    endtask

    task automatic test_comb_exhaustive();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drive_bit(v[2], v[1], v[0], 1'b0);
        end
        exp_q.delete();
        checks++;
        a = 1'b0; b = 1'b1; cin = 1'b1; #1;
        if ({s, Cout} !== 2'b01) begin
            failures++;
            $display("FAIL comb_011: got s=%0b Cout=%0b expected s=0 Cout=1", s, Cout);
        end
    endtask

    task automatic test_registered();
        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({s_q, cout_q, valid_q} !== 3'b000) begin
            failures++;
            $display("FAIL during_reset: got s_q=%0b cout_q=%0b valid_q=%0b expected 0 0 0", s_q, cout_q, valid_q);
        end
        #1 rst = 1'b0;
        model_c = 1'b0;
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        clock_edge();
        checks++;
        if ({s_q, cout_q, valid_q} !== 3'b011) begin
            failures++;
            $display("FAIL first_edge: got s_q=%0b cout_q=%0b valid_q=%0b expected 0 1 1", s_q, cout_q, valid_q);
        end
    endtask

    task automatic test_serial_add();
        logic [3:0] wa = 4'b0111;
        logic [3:0] wb = 4'b0001;
        logic [3:0] sq_seq;
        logic [3:0] cq_seq;
        for (int k = 0; k < 4; k++) begin
            drive_bit(wa[k], wb[k], 1'b0, k != 0);
            clock_edge();
            sq_seq[k] = s_q;
            cq_seq[k] = cout_q;
        end
        checks++;
        if (sq_seq !== 4'b1000) begin
            failures++;
            $display("FAIL serial_sum: got s_q bits (msb..lsb)=%b expected 1000", sq_seq);
        end
        checks++;
        if (cq_seq !== 4'b0111) begin
            failures++;
            $display("FAIL serial_carry: got cout_q per edge (msb..lsb)=%b expected 0111", cq_seq);
        end
    endtask

    task automatic test_reset_mid_word();
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        clock_edge();
        drive_bit(1'b1, 1'b0, 1'b0, 1'b1);
        clock_edge();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cout_q, valid_q} !== 2'b00) begin
            failures++;
            $display("FAIL midword_reset: got cout_q=%0b valid_q=%0b expected 0 0", cout_q, valid_q);
        end
        model_c = 1'b0;
        serial_en = 1'b1; a = 1'b1; b = 1'b0;
        #1;
        checks++;
        if ({s, Cout} !== 2'b10) begin
            failures++;
            $display("FAIL midword_comb: got s=%0b Cout=%0b expected s=1 Cout=0", s, Cout);
        end
        @(negedge clk);
        rst = 1'b0;
        serial_en = 1'b0;
    endtask

    task automatic test_carry_select();
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        clock_edge();
        a = 1'b0; b = 1'b0; cin = 1'b0; serial_en = 1'b1;
        #1;
        checks++;
        if (s !== 1'b1) begin
            failures++;
            $display("FAIL select_serial: got s=%0b expected 1", s);
        end
        serial_en = 1'b0;
        #1;
        checks++;
        if (s !== 1'b0) begin
            failures++;
            $display("FAIL select_cin: got s=%0b expected 0", s);
        end
    endtask

    // Random 8-bit words added serially with no gaps between words.
    task automatic test_back_to_back();
        for (int w = 0; w < 12; w++) begin
            logic [7:0] wa, wb, res;
            logic       c0;
            logic [8:0] exp_sum;
            wa = 8'($urandom_range(0, 255));
            wb = 8'($urandom_range(0, 255));
            c0 = 1'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) begin
                drive_bit(wa[k], wb[k], c0, k != 0);
                clock_edge();
                res[k] = s_q;
            end
            exp_sum = {1'b0, wa} + {1'b0, wb} + {8'd0, c0};
            checks++;
            if ({cout_q, res} !== exp_sum) begin
                failures++;
                $display("FAIL word_add %0d+%0d+%0d: got %0d expected %0d", wa, wb, c0, {cout_q, res}, exp_sum);
            end
        end
    endtask

    initial begin
        model_c = 1'b0;
        test_reset();
        test_comb_exhaustive();
        test_registered();
        test_serial_add();
        test_reset_mid_word();
        test_carry_select();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
